// File: rtl/sha_sequencer.sv
// Control stage ahead of the SHA-256 round unit: latches a block and chaining
// value, steps round/Kt through 64 rounds, then captures the unit's H1 as the digest.
module sha_sequencer (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [511:0] M_in,
  input  logic [255:0] H0_in,
  input  logic [255:0] H1,
  output logic         busy,
  output logic         done,
  output logic [5:0]   round,
  output logic [31:0]  Kt,
  output logic [511:0] M,
  output logic [255:0] H0,
  output logic [255:0] digest
);

  typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;

  localparam logic [0:63][31:0] K_TABLE = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t state;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking would chain updates within one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the wide M/H0/digest registers are reset too, so an aborted
      // block leaves no stale data visible to the round unit or the host.
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      round  <= '0;
      Kt     <= '0;
      M      <= '0;
      H0     <= '0;
      digest <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            M     <= M_in;
            H0    <= H0_in;
            round <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Kt trails round by one cycle to match the round unit's S0/Wt register.
          Kt <= K_TABLE[round];
          if (round == 6'd63) begin
            round <= '0;
            state <= FINAL;
          end else begin
            round <= round + 6'd1;
          end
        end
        FINAL: begin
          digest <= H1;
          done   <= 1'b1;
          busy   <= 1'b0;
          Kt     <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_sequencer.sv
// Self-checking bench: a cycle-count model of the sequencer plus a behavioural
// SHA-256 compression standing in for the round unit's H1 output.
module tb_sha_sequencer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [511:0] M_in = '0;
  logic [255:0] H0_in = '0;
  logic [255:0] H1;
  logic         busy, done;
  logic [5:0]   round;
  logic [31:0]  Kt;
  logic [511:0] M;
  logic [255:0] H0, digest;

  sha_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .M_in(M_in), .H0_in(H0_in),
    .H1(H1), .busy(busy), .done(done), .round(round), .Kt(Kt), .M(M),
    .H0(H0), .digest(digest)
  );

  always #5 clk = ~clk;

  localparam logic [0:63][31:0] KT = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] M_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] M_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [511:0] m, input logic [255:0] h);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = m[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3))
           + w[t-7] + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
    {a, b, c, d, e, f, g, hh} = h;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + h[255:224], b + h[223:192], c + h[191:160], d + h[159:128],
            e + h[127:96],  f + h[95:64],   g + h[63:32],   hh + h[31:0]};
  endfunction

  // Reference model: k counts edges since the accepted start.
  bit           m_busy = 1'b0, m_done = 1'b0;
  int           m_k = 0;
  logic [5:0]   m_round = '0;
  logic [31:0]  m_kt = '0;
  logic [511:0] m_M = '0;
  logic [255:0] m_H0 = '0, m_digest = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_done = 0; m_k = 0; m_round = '0; m_kt = '0;
      m_M = '0; m_H0 = '0; m_digest = '0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_k = 0; m_round = '0; m_M = M_in; m_H0 = H0_in;
        end
      end else begin
        m_k++;
        if (m_k <= 63) begin
          m_round = 6'(m_k); m_kt = KT[m_k - 1];
        end else if (m_k == 64) begin
          m_round = '0; m_kt = KT[63];
        end else begin
          m_digest = sha_compress(m_M, m_H0);
          m_done = 1; m_busy = 0; m_kt = '0; m_round = '0;
        end
      end
    end
  end

  // Round-unit stand-in: H1 is only meaningful in the final cycle, garbage otherwise.
  logic [255:0] junk = '0;
  always @(negedge clk) for (int i = 0; i < 8; i++) junk[32*i +: 32] = $urandom;

  always_comb begin
    H1 = junk;
    if (m_busy && m_k == 64) H1 = sha_compress(M, H0);
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("round", round, m_round);
      check("Kt", Kt, m_kt);
      check("M", M, m_M);
      check("H0", H0, m_H0);
      check("digest", digest, m_digest);
    end
  end

  task automatic wait_done(input int budget, output int c);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic pulse_start(input logic [511:0] m, input logic [255:0] h, output int e0);
    @(negedge clk);
    start = 1'b1; M_in = m; H0_in = h;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
  endtask

  initial begin
    int e0, d1, d2, busy_n, done_n, done_r, r;
    bit idle_ok, seen_done, found;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_digest", digest, 256'h0);

    // Idle stability
    idle_ok = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || round !== 6'd0 || Kt !== 32'd0 || digest !== 256'd0)
        idle_ok = 1'b0;
    end
    check("idle_stable", idle_ok, 1'b1);

    // "abc" with sequencing checks
    pulse_start(M_ABC, IV, e0);
    busy_n = 0; done_n = 0; done_r = -1;
    for (int i = 0; i < 70; i++) begin
      r = cyc - e0;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin done_n++; done_r = r; end
      if (r == 0) check("seq_r0", {round, Kt}, {6'd0, 32'h0});
      if (r == 1) check("seq_r1", {round, Kt}, {6'd1, 32'h428a2f98});
      if (r == 64) check("seq_final", {busy, round, Kt}, {1'b1, 6'd0, 32'hc67178f2});
      if (r == 66) check("seq_after", Kt, 32'h0);
      @(negedge clk);
    end
    check("busy_cycles", busy_n, 65);
    check("done_cycles", done_n, 1);
    check("done_edge", done_r, 65);
    check("abc_digest", digest, DIG_ABC);

    // Input isolation: inputs churn, stray start at round 20
    pulse_start(M_ABC, IV, e0);
    d1 = -1;
    for (int i = 0; i < 80; i++) begin
      if (done === 1'b1) begin d1 = cyc; break; end
      M_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      H0_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      start = (round == 6'd20);
      @(negedge clk);
    end
    start = 1'b0;
    check("iso_done_edge", d1 - e0, 65);
    check("iso_M", M, M_ABC);
    check("iso_digest", digest, DIG_ABC);

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1; M_in = M_ABC; H0_in = IV;
    wait_done(80, d1);
    check("b2b_first", digest, DIG_ABC);
    M_in = M_EMPTY;
    @(negedge clk);
    check("b2b_accept", busy, 1'b1);
    start = 1'b0;
    wait_done(80, d2);
    check("b2b_second", digest, DIG_EMPTY);
    check("b2b_spacing", d2 - d1, 66);

    // Asynchronous reset at round 40
    pulse_start(M_ABC, IV, e0);
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (round == 6'd40) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("rst_reach40", found, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async", {busy, done, round, Kt, M, H0, digest}, '0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    seen_done = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("rst_no_done", seen_done, 1'b0);
    pulse_start(M_ABC, IV, e0);
    wait_done(80, d1);
    check("rst_abc_digest", digest, DIG_ABC);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      start = ($urandom_range(3) == 0);
      M_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      H0_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    start = 1'b0;
    repeat (70) @(negedge clk);
    check("end_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
